// File: rtl/nvio_regfile_valid_if.sv
// nvio_regfile_valid_if: bundles the dispatch stream, commit ports, branch-miss
// restore inputs and the registered valid outputs of the rename-stage valid
// tracker.
//   master : driver side (dispatch/commit/restore as outputs, rf_v/pend_cnt in)
//   slave  : tracker side (the reverse)
interface nvio_regfile_valid_if #(
    parameter int unsigned AREGS  = 128,
    parameter int unsigned RBIT   = 6,
    parameter int unsigned RIDW   = 5,
    parameter int unsigned QSLOTS = 3
);
    logic              branchmiss;
    logic [AREGS-1:0]  livetgt;
    logic [QSLOTS-1:0] slotvd;
    logic [QSLOTS-1:0] queuedOn;
    logic [QSLOTS-1:0] slot_rfw;
    logic [RBIT:0]     Rd        [0:QSLOTS-1];
    logic [RBIT:0]     Rd2       [0:QSLOTS-1];
    logic [RIDW:0]     rf_source [0:AREGS-1];
    logic [1:0]        cmt_v;
    logic [RBIT:0]     cmt_tgt   [0:1];
    logic [RBIT:0]     cmt_tgt2  [0:1];
    logic [RIDW-1:0]   cmt_id    [0:1];
    logic [AREGS-1:0]  rf_v;
    logic [7:0]        pend_cnt;

    modport master (
        output branchmiss, livetgt, slotvd, queuedOn, slot_rfw, Rd, Rd2,
               rf_source, cmt_v, cmt_tgt, cmt_tgt2, cmt_id,
        input  rf_v, pend_cnt
    );

    modport slave (
        input  branchmiss, livetgt, slotvd, queuedOn, slot_rfw, Rd, Rd2,
               rf_source, cmt_v, cmt_tgt, cmt_tgt2, cmt_id,
        output rf_v, pend_cnt
    );
endinterface

// File: rtl/nvio_regfile_valid.sv
// nvio_regfile_valid: per-architectural-register valid tracker for the rename
// stage. Dispatch clears a register's valid bit when an instruction targeting
// it is queued; commit sets it again when the committing ROB id is still the
// register's recorded producer; a branch miss rebuilds the state from the
// surviving-target mask. Registers 0 and AREGS/2 are hard-wired valid.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (rf_v all ones, pend_cnt 0)
//   bus  : slave side of nvio_regfile_valid_if (dispatch, commit, restore
//          inputs; registered rf_v and pend_cnt outputs)
module nvio_regfile_valid #(
    parameter int unsigned AREGS  = 128,
    parameter int unsigned RBIT   = 6,
    parameter int unsigned RIDW   = 5,
    parameter int unsigned QSLOTS = 3
) (
    input  logic                clk,
    input  logic                rst,
    nvio_regfile_valid_if.slave bus
);
    localparam int unsigned HALF = AREGS / 2;

    logic [QSLOTS-1:0] taken;
    logic              chain_ok;
    logic [AREGS-1:0]  clr_m;
    logic [AREGS-1:0]  set_m;
    logic [AREGS-1:0]  nxt_v;
    logic [7:0]        nxt_cnt;
    logic [AREGS-1:0]  rf_v_q;
    logic [7:0]        pend_q;

    // Slot acceptance: a slot only counts while every older valid slot was
    // also queued; the first valid-but-unqueued slot breaks the chain.
    always_comb begin
        taken    = '0;
        chain_ok = 1'b1;
        for (int unsigned i = 0; i < QSLOTS; i++) begin
            taken[i] = bus.slotvd[i] & bus.queuedOn[i] & bus.slot_rfw[i] & chain_ok;
            if (bus.slotvd[i] && !bus.queuedOn[i])
                chain_ok = 1'b0;
        end
    end

    always_comb begin
        clr_m = '0;
        for (int unsigned i = 0; i < QSLOTS; i++) begin
            if (taken[i]) begin
                clr_m[bus.Rd[i]]  = 1'b1;
                clr_m[bus.Rd2[i]] = 1'b1;
            end
        end
    end

    // Commit sets only when the committing id is still the recorded producer;
    // the secondary flag bit of rf_source takes no part in the match.
    always_comb begin
        set_m = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            if (bus.cmt_v[k]) begin
                if (bus.rf_source[bus.cmt_tgt[k]][RIDW-1:0] == bus.cmt_id[k])
                    set_m[bus.cmt_tgt[k]] = 1'b1;
                if (bus.rf_source[bus.cmt_tgt2[k]][RIDW-1:0] == bus.cmt_id[k])
                    set_m[bus.cmt_tgt2[k]] = 1'b1;
            end
        end
    end

    // Normal cycle: clear beats set. Branch miss: restore, ignore dispatch,
    // sets on top. Forced registers override everything.
    always_comb begin
        if (bus.branchmiss)
            nxt_v = ~bus.livetgt | set_m;
        else
            nxt_v = (rf_v_q | set_m) & ~clr_m;
        nxt_v[0]    = 1'b1;
        nxt_v[HALF] = 1'b1;
    end

    always_comb begin
        nxt_cnt = '0;
        for (int unsigned i = 0; i < AREGS; i++) begin
            if (!nxt_v[i])
                nxt_cnt = nxt_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_v_q <= '1;
            pend_q <= '0;
        end else begin
            rf_v_q <= nxt_v;
            pend_q <= nxt_cnt;
        end
    end

    assign bus.rf_v     = rf_v_q;
    assign bus.pend_cnt = pend_q;
endmodule

// File: tb/tb_nvio_regfile_valid.sv
// tb_nvio_regfile_valid: directed-vector bench for nvio_regfile_valid.
// Expected valid vectors and pending counts are hand-computed per step.
module tb_nvio_regfile_valid;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [127:0] exp_v;
    logic [127:0] ones;

    always #5 clk = ~clk;

    nvio_regfile_valid_if #(.AREGS(128), .RBIT(6), .RIDW(5), .QSLOTS(3)) bus ();

    nvio_regfile_valid #(.AREGS(128), .RBIT(6), .RIDW(5), .QSLOTS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.branchmiss = 1'b0;
        bus.livetgt    = '0;
        bus.slotvd     = '0;
        bus.queuedOn   = '0;
        bus.slot_rfw   = '0;
        bus.cmt_v      = '0;
        for (int i = 0; i < 3; i++) begin
            bus.Rd[i]  = '0;
            bus.Rd2[i] = '0;
        end
        for (int k = 0; k < 2; k++) begin
            bus.cmt_tgt[k]  = '0;
            bus.cmt_tgt2[k] = '0;
            bus.cmt_id[k]   = '0;
        end
    endtask

    task automatic dispatch(input logic [2:0] vd, input logic [2:0] qo, input logic [2:0] rfw,
                            input logic [6:0] r0, input logic [6:0] r1, input logic [6:0] r2,
                            input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
        bus.slotvd   = vd;
        bus.queuedOn = qo;
        bus.slot_rfw = rfw;
        bus.Rd[0] = r0;  bus.Rd[1] = r1;  bus.Rd[2] = r2;
        bus.Rd2[0] = s0; bus.Rd2[1] = s1; bus.Rd2[2] = s2;
    endtask

    task automatic commit(input int port, input logic [6:0] tgt, input logic [6:0] tgt2,
                          input logic [4:0] id);
        bus.cmt_v[port]    = 1'b1;
        bus.cmt_tgt[port]  = tgt;
        bus.cmt_tgt2[port] = tgt2;
        bus.cmt_id[port]   = id;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ones = '1;
        for (int r = 0; r < 128; r++) bus.rf_source[r] = '0;
        idle();

        // Reset beats branch miss and dispatch in the same cycle.
        rst = 1'b1;
        bus.branchmiss = 1'b1;
        dispatch(3'b111, 3'b111, 3'b111, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9, 7'd10);
        step();
        rst = 1'b0;
        idle();
        exp_v = ones;
        check("reset_rf_v", bus.rf_v, exp_v);
        check("reset_pend", {120'd0, bus.pend_cnt}, 128'd0);

        // Dispatch 5/6/7, Rd2=0 (forced).
        dispatch(3'b111, 3'b111, 3'b111, 7'd5, 7'd6, 7'd7, 7'd0, 7'd0, 7'd0);
        step();
        idle();
        exp_v[5] = 1'b0; exp_v[6] = 1'b0; exp_v[7] = 1'b0;
        check("disp_rf_v", bus.rf_v, exp_v);
        check("disp_r0", {127'd0, bus.rf_v[0]}, 128'd1);
        check("disp_pend", {120'd0, bus.pend_cnt}, 128'd3);

        // Matching commit on reg 6.
        bus.rf_source[6] = 6'd10;
        commit(0, 7'd6, 7'd0, 5'd10);
        step();
        idle();
        exp_v[6] = 1'b1;
        check("cmt_rf_v", bus.rf_v, exp_v);
        check("cmt_pend", {120'd0, bus.pend_cnt}, 128'd2);

        // Stale commit: producer id 4, committing id 3 (flag bit set, ignored).
        dispatch(3'b001, 3'b001, 3'b001, 7'd9, 7'd0, 7'd0, 7'd9, 7'd0, 7'd0);
        step();
        idle();
        exp_v[9] = 1'b0;
        check("disp9_pend", {120'd0, bus.pend_cnt}, 128'd3);
        bus.rf_source[9] = {1'b1, 5'd4};
        commit(1, 7'd9, 7'd9, 5'd3);
        step();
        idle();
        check("stale_rf_v", bus.rf_v, exp_v);
        check("stale_pend", {120'd0, bus.pend_cnt}, 128'd3);

        // Dispatch clear beats matching commit on reg 12.
        bus.rf_source[12] = {1'b1, 5'd7};
        commit(0, 7'd12, 7'd12, 5'd7);
        dispatch(3'b001, 3'b001, 3'b001, 7'd12, 7'd0, 7'd0, 7'd12, 7'd0, 7'd0);
        step();
        idle();
        exp_v[12] = 1'b0;
        check("clr_beats_set", bus.rf_v, exp_v);
        check("clr_beats_pend", {120'd0, bus.pend_cnt}, 128'd4);

        // Both commit ports set reg 12 together.
        commit(0, 7'd12, 7'd0, 5'd7);
        commit(1, 7'd12, 7'd12, 5'd7);
        step();
        idle();
        exp_v[12] = 1'b1;
        check("dual_set", bus.rf_v, exp_v);
        check("dual_set_pend", {120'd0, bus.pend_cnt}, 128'd3);

        // Chain broken at slot 1: only slot 0 (30, 33) clears.
        dispatch(3'b111, 3'b101, 3'b111, 7'd30, 7'd31, 7'd32, 7'd33, 7'd34, 7'd35);
        step();
        idle();
        exp_v[30] = 1'b0; exp_v[33] = 1'b0;
        check("chain_rf_v", bus.rf_v, exp_v);
        check("chain_pend", {120'd0, bus.pend_cnt}, 128'd5);

        // Empty slot 1 does not break chain; slot 1 targets untouched.
        dispatch(3'b101, 3'b101, 3'b111, 7'd40, 7'd41, 7'd42, 7'd40, 7'd41, 7'd42);
        step();
        idle();
        exp_v[40] = 1'b0; exp_v[42] = 1'b0;
        check("gap_rf_v", bus.rf_v, exp_v);
        check("gap_pend", {120'd0, bus.pend_cnt}, 128'd7);

        // slot_rfw low: no clear, chain continues to slot 1.
        dispatch(3'b011, 3'b011, 3'b010, 7'd50, 7'd51, 7'd0, 7'd50, 7'd51, 7'd0);
        step();
        idle();
        exp_v[51] = 1'b0;
        check("rfw_rf_v", bus.rf_v, exp_v);
        check("rfw_pend", {120'd0, bus.pend_cnt}, 128'd8);

        // Dispatch to forced registers 64 and 0 has no effect.
        dispatch(3'b001, 3'b001, 3'b001, 7'd64, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
        step();
        idle();
        check("forced_rf_v", bus.rf_v, exp_v);
        check("forced_pend", {120'd0, bus.pend_cnt}, 128'd8);

        // Branch miss: livetgt 3, 40, 64; dispatch 20 ignored; commit 40 wins.
        bus.branchmiss = 1'b1;
        bus.livetgt[3] = 1'b1; bus.livetgt[40] = 1'b1; bus.livetgt[64] = 1'b1;
        dispatch(3'b001, 3'b001, 3'b001, 7'd20, 7'd0, 7'd0, 7'd20, 7'd0, 7'd0);
        bus.rf_source[40] = 6'd2;
        commit(1, 7'd40, 7'd40, 5'd2);
        step();
        idle();
        exp_v = ones;
        exp_v[3] = 1'b0;
        check("bmiss_rf_v", bus.rf_v, exp_v);
        check("bmiss_pend", {120'd0, bus.pend_cnt}, 128'd1);

        // Branch miss with every register live: maximum pending count.
        bus.branchmiss = 1'b1;
        bus.livetgt    = ones;
        step();
        idle();
        exp_v = '0;
        exp_v[0] = 1'b1; exp_v[64] = 1'b1;
        check("max_rf_v", bus.rf_v, exp_v);
        check("max_pend", {120'd0, bus.pend_cnt}, 128'd126);

        // Mid-stream reset with a commit pending.
        rst = 1'b1;
        commit(0, 7'd6, 7'd6, 5'd10);
        dispatch(3'b111, 3'b111, 3'b111, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6);
        step();
        rst = 1'b0;
        idle();
        check("rst2_rf_v", bus.rf_v, ones);
        check("rst2_pend", {120'd0, bus.pend_cnt}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
